// File: rtl/aes_pkg.sv
// Shared AES definitions: word/key types, round constants and the inverse
// key-schedule FSM state encoding.
package aes_pkg;

    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned AES_KEY_W   = 128;
    localparam int unsigned AES_ROUNDS  = 10;
    localparam int unsigned AES_ROUND_W = 4;

    typedef logic [AES_WORD_W-1:0]  aes_word_t;
    typedef logic [AES_KEY_W-1:0]   aes_key_t;
    typedef logic [AES_ROUND_W-1:0] aes_round_t;

    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } inv_ks_state_t;

    // Round constant lookup; rounds outside 1..10 contribute nothing.
    function automatic logic [7:0] aes_rcon(input aes_round_t r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (r == AES_ROUND_W'(i)) v = AES_RCON[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Control and round-key stream bundle for inv_key_schedule.
// The abort signal exists only when INV_KEY_ABORT_EN is defined.
interface inv_key_schedule_if;
    import aes_pkg::*;

    logic       start;
    aes_key_t   last_key;
    logic       busy;
    aes_key_t   key_out;
    aes_round_t key_round;
    logic       key_valid;
    logic       key_ready;
`ifdef INV_KEY_ABORT_EN
    logic       abort;

    modport master (
        output start, last_key, key_ready, abort,
        input  busy, key_out, key_round, key_valid
    );
    modport slave (
        input  start, last_key, key_ready, abort,
        output busy, key_out, key_round, key_valid
    );
`else
    modport master (
        output start, last_key, key_ready,
        input  busy, key_out, key_round, key_valid
    );
    modport slave (
        input  start, last_key, key_ready,
        output busy, key_out, key_round, key_valid
    );
`endif

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte per instance.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst_c
);

    // Entry for byte x sits at bits [8*(255-x) +: 8]; row 0 is the MSB end.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst_c = SBOX[{~data, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: walks round keys 10 down to 0 over
// a valid/ready stream. Optional abort input under INV_KEY_ABORT_EN.
module inv_key_schedule
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    inv_key_schedule_if.slave bus
);

    inv_ks_state_t state_q, state_d;
    aes_key_t      key_q, key_d;
    aes_round_t    round_q, round_d;
    logic          busy_q;
    logic          valid_q;

    logic          accept_c;
    logic          abort_c;

    aes_word_t     w0, w1, w2, w3;
    aes_word_t     p0, p1, p2, p3;
    aes_word_t     rot_c, sub_c;
    aes_key_t      prev_c;

`ifdef INV_KEY_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    assign accept_c = valid_q & bus.key_ready;

    // One inverse expansion step from the current round key.
    assign {w0, w1, w2, w3} = key_q;
    assign p3    = w3 ^ w2;
    assign p2    = w2 ^ w1;
    assign p1    = w1 ^ w0;
    assign rot_c = {p3[23:0], p3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .data    (rot_c[8*i +: 8]),
            .subst_c (sub_c[8*i +: 8])
        );
    end

    assign p0     = w0 ^ sub_c ^ {aes_rcon(round_q), 24'h000000};
    assign prev_c = {p0, p1, p2, p3};

    // Next-state and datapath load selection.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !abort_c) begin
                    state_d = RUN;
                    key_d   = bus.last_key;
                    round_d = AES_ROUND_W'(AES_ROUNDS);
                end
            end
            RUN: begin
                if (abort_c) begin
                    state_d = IDLE;
                    round_d = '0;
                end else if (accept_c) begin
                    if (round_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        key_d   = prev_c;
                        round_d = round_q - aes_round_t'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            busy_q  <= (state_d == RUN);
            valid_q <= (state_d == RUN);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.key_valid = valid_q;
    assign bus.key_out   = key_q;
    assign bus.key_round = round_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using the FIPS-197 AES-128 schedule.
// Define INV_KEY_ABORT_EN to include the abort scenario.
module tb_inv_key_schedule;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    inv_key_schedule_if bus ();

    inv_key_schedule dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int beats;

    aes_key_t exp_key [0:10];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consume beats from round start_r down to 0 with a cyclic ready pattern.
    task automatic consume(input int start_r, input logic [3:0] pat, output int nbeats);
        int         r;
        int         cyc;
        logic       stalled;
        aes_key_t   hk;
        aes_round_t hr;
        r       = start_r;
        cyc     = 0;
        stalled = 1'b0;
        hk      = '0;
        hr      = '0;
        nbeats  = 0;
        while (r >= 0 && cyc < 100) begin
            if (stalled && bus.key_valid) begin
                chk("hold_key", bus.key_out, hk);
                chk("hold_round", 128'(bus.key_round), 128'(hr));
            end
            bus.key_ready = pat[2'(cyc)];
            stalled = bus.key_valid && !bus.key_ready;
            hk = bus.key_out;
            hr = bus.key_round;
            if (bus.key_valid && bus.key_ready) begin
                chk("beat_round", 128'(bus.key_round), 128'(r));
                chk("beat_key", bus.key_out, exp_key[r]);
                r--;
                nbeats++;
            end
            step();
            cyc++;
        end
        chk("walk_done_in_budget", 128'(cyc < 100), 128'(1));
    endtask

    initial begin
        exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.last_key  = '0;
        bus.key_ready = 1'b0;
`ifdef INV_KEY_ABORT_EN
        bus.abort     = 1'b0;
`endif
        repeat (3) step();
        chk("reset_busy", 128'(bus.busy), 128'(0));
        chk("reset_valid", 128'(bus.key_valid), 128'(0));
        chk("reset_key", bus.key_out, 128'(0));
        chk("reset_round", 128'(bus.key_round), 128'(0));
        rst_n = 1'b1;
        step();

        // FIPS-197 walk with ready held high
        bus.key_ready = 1'b1;
        bus.last_key  = exp_key[10];
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_busy", 128'(bus.busy), 128'(1));
        chk("start_valid", 128'(bus.key_valid), 128'(1));
        chk("start_round", 128'(bus.key_round), 128'(10));
        consume(10, 4'b1111, beats);
        chk("fips_beats", 128'(beats), 128'(11));
        chk("fips_end_busy", 128'(bus.busy), 128'(0));
        chk("fips_end_valid", 128'(bus.key_valid), 128'(0));
        chk("fips_end_key", bus.key_out, exp_key[0]);
        chk("fips_end_round", 128'(bus.key_round), 128'(0));

        // Backpressure with ready pattern 1-0-0-1
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        consume(10, 4'b1001, beats);
        chk("bp_beats", 128'(beats), 128'(11));
        chk("bp_end_valid", 128'(bus.key_valid), 128'(0));

        // start while busy is ignored
        step();
        bus.key_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        chk("busy_start_round5", 128'(bus.key_round), 128'(5));
        bus.key_ready = 1'b0;
        bus.last_key  = 128'h00112233445566778899aabbccddeeff;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_start_round_hold", 128'(bus.key_round), 128'(5));
        chk("busy_start_key_hold", bus.key_out, exp_key[5]);
        chk("busy_start_busy", 128'(bus.busy), 128'(1));
        consume(5, 4'b1111, beats);
        chk("busy_start_beats", 128'(beats), 128'(6));
        chk("busy_start_end_key", bus.key_out, exp_key[0]);

        // Asynchronous reset at round 6
        step();
        bus.last_key = exp_key[10];
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        chk("rst_mid_round6", 128'(bus.key_round), 128'(6));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 128'(bus.busy), 128'(0));
        chk("rst_mid_valid", 128'(bus.key_valid), 128'(0));
        chk("rst_mid_key", bus.key_out, 128'(0));
        chk("rst_mid_round", 128'(bus.key_round), 128'(0));
        step();
        rst_n = 1'b1;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("rst_restart_valid", 128'(bus.key_valid), 128'(1));
        chk("rst_restart_round", 128'(bus.key_round), 128'(10));
        chk("rst_restart_key", bus.key_out, exp_key[10]);
        consume(10, 4'b1111, beats);
        chk("rst_restart_beats", 128'(beats), 128'(11));

        // Back-to-back with start held high
        step();
        bus.start = 1'b1;
        step();
        consume(10, 4'b1111, beats);
        chk("b2b_first_beats", 128'(beats), 128'(11));
        chk("b2b_gap_valid", 128'(bus.key_valid), 128'(0));
        step();
        bus.start = 1'b0;
        chk("b2b_second_valid", 128'(bus.key_valid), 128'(1));
        chk("b2b_second_round", 128'(bus.key_round), 128'(10));
        chk("b2b_second_key", bus.key_out, exp_key[10]);
        consume(10, 4'b1111, beats);
        chk("b2b_second_beats", 128'(beats), 128'(11));

`ifdef INV_KEY_ABORT_EN
        // Abort together with the round-7 accept
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        chk("abort_round7", 128'(bus.key_round), 128'(7));
        chk("abort_key7", bus.key_out, exp_key[7]);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_valid", 128'(bus.key_valid), 128'(0));
        chk("abort_busy", 128'(bus.busy), 128'(0));
        chk("abort_round", 128'(bus.key_round), 128'(0));
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_idle_valid", 128'(bus.key_valid), 128'(0));
        chk("abort_idle_busy", 128'(bus.busy), 128'(0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

- Iterative AES-128 inverse key-schedule engine for the decryption datapath.
- Takes the round-10 key and walks the schedule backwards, one round per accepted output beat.
- Emits round keys 10, 9, …, 0 over a valid/ready stream so the inverse cipher consumes them in order.
- Inverse counterpart of the combinational forward `roundKey` expansion step.
- Byte packing is column-major, the same as `roundKey`: key[127:120] = row0/col0, key[119:112] = row1/col0, …, key[7:0] = row3/col3; word0 = key[127:96].

## Interface
- No parameters. AES-128 only, 10 rounds fixed.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to begin a walk; sampled only in IDLE.
- last_key  in  128  round-10 key; captured on the cycle start is accepted.
- busy  out  1  high in RUN.
- key_out  out  128  current round key.
- key_round  out  4  round index of key_out, 10 down to 0.
- key_valid  out  1  key_out/key_round valid.
- key_ready  in  1  consumer accepts the beat when key_valid & key_ready.
- abort  in  1  present only with INV_KEY_ABORT_EN.

## Operation
- FSM has two states:
  - IDLE → RUN on start; latch last_key, set round=10.
  - RUN → IDLE on an accepted beat with round==0.
- Inverse step, computed from current words w0..w3 to give previous words:
  - p3=w3^w2, p2=w2^w1, p1=w1^w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {RCON[round],24'h0}.
  - RotWord: {b1,b2,b3,b0}.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- On an accepted beat with round>0: key register ← {p0,p1,p2,p3}, round ← round-1.
- While key_valid & !key_ready: key_out and key_round hold stable; no advance.
- start is ignored while busy. start coinciding with the final accept is also ignored; a new walk begins no earlier than the first IDLE cycle.
- key_round never underflows. Round 0 is the last beat.

## Timing
- Reset values: busy=0, key_valid=0, key_out=0, key_round=0, state=IDLE.
- Latency: start accepted at cycle N → key_valid=1 with the round-10 key at N+1.
- With key_ready held high, round r is presented at N+1+(10-r); round 0 is at N+11.
- key_valid = (state==RUN), registered, no combinational path from key_ready.
- The inverse step is one combinational cycle: 4 S-box lookups + XORs. key_out is taken directly from the register.
- After the final accept: busy=0 and key_valid=0 in the next cycle. key_out and key_round keep their last values.
- rst_n asserted mid-walk clears everything immediately (async). The walk is not resumed.

## Configuration
- INV_KEY_ABORT_EN defined:
  - adds the abort input.
  - abort high in RUN → IDLE next cycle, key_valid=0, key_round=0.
  - abort beats a simultaneous accept: the beat counts as transferred but no further beats follow.
  - abort in IDLE has no effect and takes priority over start.
- INV_KEY_ABORT_EN undefined: the port is absent and a walk always runs to round 0.

## Structure
- Shared package aes_pkg holds:
  - typedef aes_word_t (32 bits).
  - typedef aes_key_t (128 bits).
  - constant AES_RCON[1:10].
  - enum inv_ks_state_t {IDLE, RUN}.
- Sub-module aes_sbox is a combinational 8-bit forward S-box. Instantiate it 4× for SubWord; it is reusable by the cipher.

## Test plan
- FIPS-197 walk: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start, key_ready=1. Required beats:
  - round 10 = last_key.
  - round 9 = ac7766f319fadc2128d12941575c006e.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - Exactly 11 beats, busy low after.
- Backpressure: same key, key_ready toggled 1-0-0-1 pseudo-randomly. Same 11-beat sequence; key_out stable whenever valid&!ready.
- start while busy at round 5: pulse start with a different last_key. Ignored; the walk finishes with the original key's round 0.
- Reset mid-walk: drop rst_n at round 6. All outputs 0 asynchronously; a new start after release produces round 10 one cycle later.
- Back-to-back: start held high throughout. Second walk's round 10 appears no earlier than 2 cycles after the round-0 accept.
- INV_KEY_ABORT_EN: abort at round 7 together with an accept. Round 7 counted; key_valid=0 next cycle; busy=0.
